up_port_fabric: RTL and testbench
=================================

# up_port_fabric

Parametrised host-bus fabric joining one CPU bridge master to NPORTS `ether_top` register slaves, plus per-port activity-LED stretching. It decodes a port-select field from the address, issues one transaction at a time to the selected port, and waits on that port's busy. It returns read data and an error flag, with an optional watchdog timeout. It sits between the SPI/JTAG CPU bridge and the port instances in the board top, and replaces the fixed two-port address-bit-31 steering and hand-written LED logic.

## Interface
Parameters:
- NPORTS, 2, number of slave ports (1..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SEL_LSB, 27, LSB of the 4-bit port-select field up_addr[SEL_LSB+3:SEL_LSB]
- TIMEOUT_CYC, 1024, watchdog limit in WAIT (cycles)
- LED_TICK_W, 23, LED window = 2^LED_TICK_W cycles

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- up_wr  in  1  write strobe, one cycle
- up_rd  in  1  read strobe, one cycle
- up_addr  in  ADDR_W  address
- up_data_wr  in  DATA_W  write data
- up_data_rd  out  DATA_W  read data, registered
- up_wait  out  1  fabric busy
- up_err  out  1  last transaction failed (bad port or timeout)
- dn_cs  out  NPORTS  one-hot slave select
- dn_wr  out  NPORTS  per-port write pulse
- dn_rd  out  NPORTS  per-port read pulse
- dn_addr  out  ADDR_W  latched address with select field forced to 0, broadcast to all ports
- dn_data_wr  out  DATA_W  latched write data, broadcast to all ports
- dn_data_rd  in  NPORTS*DATA_W  per-port read data; port i occupies [i*DATA_W +: DATA_W]
- dn_wait  in  NPORTS  per-port busy
- act_tx, act_rx  in  NPORTS  raw per-port activity pulses
- led_tx, led_rx  out  NPORTS  stretched LEDs, active-low

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- Accepting a strobe:
  - A strobe (up_wr|up_rd) is accepted in IDLE or DONE.
  - On acceptance, latch addr, data, direction and sel; clear up_err; go to ISSUE.
  - Strobes in ISSUE/WAIT are ignored.
  - up_wr and up_rd together: treated as write.
- ISSUE:
  - sel < NPORTS: dn_cs[sel]=1 and the dn_wr[sel] or dn_rd[sel] pulse for exactly this cycle; go to WAIT.
  - sel >= NPORTS: no dn_* activity; go to DONE with up_err=1 and up_data_rd=32'hDEAD_BEEF.
- WAIT:
  - dn_cs[sel] stays high.
  - Each cycle sample dn_wait[sel]. When it is 0, register dn_data_rd[sel] into up_data_rd (reads only; writes leave it unchanged) and go to DONE.
- DONE: one cycle, dn_cs=0. Next state is IDLE, or ISSUE if a new strobe is present.
- up_wait = (state==ISSUE)|(state==WAIT).
- up_data_rd and up_err hold until the next completion or next acceptance respectively.
- LEDs:
  - Per port/direction, a sticky flag is set by the act pulse.
  - At each window tick (free-running counter of LED_TICK_W bits wraps), LED register <= flag, and flag <= the act value in that cycle.
  - Output is the inverted LED register.
- Reset values:
  - state IDLE; up_wait 0, up_err 0, up_data_rd 0.
  - dn_cs/dn_wr/dn_rd 0; dn_addr/dn_data_wr 0.
  - LED counter 0, flags 0, led_tx/led_rx all 1 (off).
- rst mid-transaction aborts it. No completion is reported, and the slave pulse is never repeated.

## Timing
- Strobe at T: ISSUE at T+1 (slave pulse), first dn_wait sample at T+2.
- Minimum latency: up_wait high T+1..T+2, low at T+3 with up_data_rd valid at T+3.
- Each extra dn_wait-high cycle in WAIT adds one cycle.
- Bad-port transaction: up_wait high at T+1 only; up_err=1 at T+2.
- Back-to-back: a strobe at T+3 (DONE) gives ISSUE at T+4.
- A LED flag set at the wrap cycle itself is seen in the following window.

## Configuration
- UP_TIMEOUT_EN defined:
  - A WAIT cycle counter runs, reset on entering WAIT.
  - When it reaches TIMEOUT_CYC-1 with dn_wait[sel] still 1, go to DONE with up_err=1 and up_data_rd=32'hDEAD_BEEF.
  - dn_cs drops in DONE.
- UP_TIMEOUT_EN undefined: no counter; WAIT persists until dn_wait[sel]=0.

## Structure
- Package up_fabric_pkg holds:
  - state enum
  - UP_ERR_DATA = 32'hDEAD_BEEF
  - SEL_W = 4
  - clog2 function
- Sub-module act_led_stretch holds one flag and one LED register with a tick input. It is instantiated 2*NPORTS times; the shared tick counter stays in the parent.

## Test plan
- NPORTS=2; read addr 32'h0800_0010 (sel=1), port 1 dn_wait low, data 32'h1234_5678 -> dn_rd[1] pulse at T+1, dn_addr 32'h0000_0010, up_data_rd 32'h1234_5678 at T+3, up_err 0.
- Write sel=0 with dn_wait[0] high 5 cycles after issue -> up_wait high exactly 7 cycles; dn_cs[0] high the whole time; up_data_rd unchanged.
- Read sel=5 with NPORTS=2 -> no dn_* activity; up_err=1 and up_data_rd=32'hDEAD_BEEF at T+2.
- UP_TIMEOUT_EN, TIMEOUT_CYC=16, dn_wait stuck high -> up_err=1 and up_wait low after 16 WAIT cycles; the next strobe works normally.
- rst asserted in WAIT, then strobe issued -> all outputs at reset values the cycle after rst; new transaction completes at minimum latency.
- LED_TICK_W=4: act_tx[1] pulse in window k -> led_tx[1]=0 for all of window k+1, then 1 again; other LEDs stay 1.

Source files
------------

// File: rtl/up_fabric_pkg.sv
// Shared types and constants for the CPU-bridge to port-slave fabric.
package up_fabric_pkg;

  localparam int SEL_W = 4;
  localparam logic [31:0] UP_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } fab_state_t;

  // Ceiling log2, never below 1 so it can size a counter directly.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/act_led_stretch.sv
// One activity LED: sticky flag collected over a window, shown during the next window (active-low).
module act_led_stretch (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic act,
  output logic led_n
);

  logic flag;
  logic led;

  always_ff @(posedge clk) begin
    if (rst) begin
      flag <= 1'b0;
      led  <= 1'b0;
    end else if (tick) begin
      // activity in the wrap cycle itself belongs to the next window
      led  <= flag;
      flag <= act;
    end else if (act) begin
      flag <= 1'b1;
    end
  end

  assign led_n = ~led;

endmodule

// File: rtl/up_port_fabric.sv
// Host-bus fabric: one CPU bridge master to NPORTS register slaves, plus per-port activity LEDs.
// Define UP_TIMEOUT_EN to enable the WAIT watchdog (TIMEOUT_CYC cycles).
//
// state | meaning
// IDLE  | no transaction, strobes accepted
// ISSUE | slave select plus one-cycle rd/wr pulse (or bad-port error)
// WAIT  | selected slave busy, sampling its dn_wait
// DONE  | result posted for one cycle, strobes accepted
module up_port_fabric
  import up_fabric_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_LSB     = 27,
  parameter int TIMEOUT_CYC = 1024,
  parameter int LED_TICK_W  = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     up_wr,
  input  logic                     up_rd,
  input  logic [ADDR_W-1:0]        up_addr,
  input  logic [DATA_W-1:0]        up_data_wr,
  output logic [DATA_W-1:0]        up_data_rd,
  output logic                     up_wait,
  output logic                     up_err,
  output logic [NPORTS-1:0]        dn_cs,
  output logic [NPORTS-1:0]        dn_wr,
  output logic [NPORTS-1:0]        dn_rd,
  output logic [ADDR_W-1:0]        dn_addr,
  output logic [DATA_W-1:0]        dn_data_wr,
  input  logic [NPORTS*DATA_W-1:0] dn_data_rd,
  input  logic [NPORTS-1:0]        dn_wait,
  input  logic [NPORTS-1:0]        act_tx,
  input  logic [NPORTS-1:0]        act_rx,
  output logic [NPORTS-1:0]        led_tx,
  output logic [NPORTS-1:0]        led_rx
);

  localparam logic [ADDR_W-1:0] SEL_MASK =
    {{(ADDR_W-SEL_W){1'b0}}, {SEL_W{1'b1}}} << SEL_LSB;
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(UP_ERR_DATA);

  if (NPORTS < 1 || NPORTS > 16 || TIMEOUT_CYC < 2 || SEL_LSB + SEL_W > ADDR_W) begin : g_param_err
    $error("up_port_fabric: illegal parameter set");
  end

  fab_state_t        state;
  logic [SEL_W-1:0]  sel_q;
  logic              wr_q;

  logic [SEL_W-1:0]  new_sel;
  logic [NPORTS-1:0] new_hot;
  logic [NPORTS-1:0] sel_hot;
  logic              sel_ok;
  logic              wait_sel;
  logic [DATA_W-1:0] rdata_sel;

  assign new_sel = up_addr[SEL_LSB +: SEL_W];

  // Port decode and read/busy muxes; selects at or above NPORTS hit nothing.
  always_comb begin
    new_hot   = '0;
    sel_hot   = '0;
    wait_sel  = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (new_sel == SEL_W'(i)) new_hot[i] = 1'b1;
      if (sel_q == SEL_W'(i)) begin
        sel_hot[i] = 1'b1;
        wait_sel   = dn_wait[i];
        rdata_sel  = dn_data_rd[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_ok = |sel_hot;

`ifdef UP_TIMEOUT_EN
  localparam int TO_W = clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel_q      <= '0;
      wr_q       <= 1'b0;
      up_wait    <= 1'b0;
      up_err     <= 1'b0;
      up_data_rd <= '0;
      dn_cs      <= '0;
      dn_wr      <= '0;
      dn_rd      <= '0;
      dn_addr    <= '0;
      dn_data_wr <= '0;
`ifdef UP_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      dn_wr <= '0;
      dn_rd <= '0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state   <= ST_IDLE;
          up_wait <= 1'b0;
          dn_cs   <= '0;
          if (up_wr || up_rd) begin
            // pulses are registered here so they appear during ISSUE
            state      <= ST_ISSUE;
            sel_q      <= new_sel;
            wr_q       <= up_wr;
            dn_addr    <= up_addr & ~SEL_MASK;
            dn_data_wr <= up_data_wr;
            up_err     <= 1'b0;
            up_wait    <= 1'b1;
            dn_cs      <= new_hot;
            if (up_wr) dn_wr <= new_hot;
            else       dn_rd <= new_hot;
          end
        end
        ST_ISSUE: begin
          if (sel_ok) begin
            state <= ST_WAIT;
`ifdef UP_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end else begin
            state      <= ST_DONE;
            up_wait    <= 1'b0;
            up_err     <= 1'b1;
            up_data_rd <= ERR_DATA;
          end
        end
        ST_WAIT: begin
          if (!wait_sel) begin
            state   <= ST_DONE;
            up_wait <= 1'b0;
            dn_cs   <= '0;
            if (!wr_q) up_data_rd <= rdata_sel;
          end
`ifdef UP_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state      <= ST_DONE;
            up_wait    <= 1'b0;
            dn_cs      <= '0;
            up_err     <= 1'b1;
            up_data_rd <= ERR_DATA;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Shared LED window counter; the tick is its wrap cycle.
  logic [LED_TICK_W-1:0] led_cnt;
  logic                  led_tick;

  always_ff @(posedge clk) begin
    if (rst) led_cnt <= '0;
    else     led_cnt <= led_cnt + 1'b1;
  end

  assign led_tick = &led_cnt;

  for (genvar i = 0; i < NPORTS; i++) begin : g_led
    act_led_stretch u_tx (
      .clk   (clk),
      .rst   (rst),
      .tick  (led_tick),
      .act   (act_tx[i]),
      .led_n (led_tx[i])
    );
    act_led_stretch u_rx (
      .clk   (clk),
      .rst   (rst),
      .tick  (led_tick),
      .act   (act_rx[i]),
      .led_n (led_rx[i])
    );
  end

endmodule

// File: tb/tb_up_port_fabric.sv
// Self-checking bench for up_port_fabric: directed scenarios plus randomized transactions and LED activity.
module tb_up_port_fabric;

  localparam int NP   = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SLSB = 27;
  localparam int TO   = 16;
  localparam int LW   = 4;
  localparam logic [31:0] ADDR_KEEP = 32'h87FF_FFFF;
  localparam logic [31:0] ERRV      = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst;
  logic              up_wr, up_rd;
  logic [AW-1:0]     up_addr;
  logic [DW-1:0]     up_data_wr;
  logic [DW-1:0]     up_data_rd;
  logic              up_wait, up_err;
  logic [NP-1:0]     dn_cs, dn_wr, dn_rd;
  logic [AW-1:0]     dn_addr;
  logic [DW-1:0]     dn_data_wr;
  logic [NP*DW-1:0]  dn_data_rd;
  logic [NP-1:0]     dn_wait;
  logic [NP-1:0]     act_tx, act_rx, led_tx, led_rx;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_rd;

  always #5 clk = ~clk;

  up_port_fabric #(
    .NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .SEL_LSB(SLSB),
    .TIMEOUT_CYC(TO), .LED_TICK_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .up_wr(up_wr), .up_rd(up_rd), .up_addr(up_addr),
    .up_data_wr(up_data_wr), .up_data_rd(up_data_rd), .up_wait(up_wait), .up_err(up_err),
    .dn_cs(dn_cs), .dn_wr(dn_wr), .dn_rd(dn_rd), .dn_addr(dn_addr), .dn_data_wr(dn_data_wr),
    .dn_data_rd(dn_data_rd), .dn_wait(dn_wait), .act_tx(act_tx), .act_rx(act_rx),
    .led_tx(led_tx), .led_rx(led_rx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] mk_addr(input logic [3:0] sel, input logic [AW-1:0] low);
    return (low & ADDR_KEEP) | (AW'(sel) << SLSB);
  endfunction

  task automatic test_reset();
    rst = 1'b1; up_wr = 1'b0; up_rd = 1'b0; up_addr = '0; up_data_wr = '0;
    dn_wait = '0; dn_data_rd = '0; act_tx = '0; act_rx = '0;
    tick(); tick();
    @(negedge clk);
    checks++; if (up_wait !== 1'b0) begin errors++; $display("FAIL rst_up_wait: got %b want 0", up_wait); end
    checks++; if (up_err !== 1'b0) begin errors++; $display("FAIL rst_up_err: got %b want 0", up_err); end
    checks++; if (up_data_rd !== 32'h0) begin errors++; $display("FAIL rst_up_data_rd: got %h want 0", up_data_rd); end
    checks++; if (dn_cs !== 2'b00) begin errors++; $display("FAIL rst_dn_cs: got %b want 00", dn_cs); end
    checks++; if ((dn_wr | dn_rd) !== 2'b00) begin errors++; $display("FAIL rst_dn_pulse: got %b/%b want 00", dn_wr, dn_rd); end
    checks++; if (dn_addr !== 32'h0) begin errors++; $display("FAIL rst_dn_addr: got %h want 0", dn_addr); end
    checks++; if (dn_data_wr !== 32'h0) begin errors++; $display("FAIL rst_dn_data_wr: got %h want 0", dn_data_wr); end
    checks++; if ({led_tx, led_rx} !== 4'hF) begin errors++; $display("FAIL rst_leds: got %b%b want 1111", led_tx, led_rx); end
    rst = 1'b0;
    exp_rd = '0;
  endtask

  task automatic test_read_min();
    @(negedge clk);
    dn_wait = '0;
    dn_data_rd = {32'h1234_5678, 32'($urandom)};
    up_rd = 1'b1; up_addr = 32'h0800_0010;
    tick(); up_rd = 1'b0;
    @(negedge clk);
    checks++; if (dn_rd !== 2'b10) begin errors++; $display("FAIL rd_pulse: got %b want 10", dn_rd); end
    checks++; if (dn_wr !== 2'b00) begin errors++; $display("FAIL rd_no_wr: got %b want 00", dn_wr); end
    checks++; if (dn_cs !== 2'b10) begin errors++; $display("FAIL rd_cs_issue: got %b want 10", dn_cs); end
    checks++; if (dn_addr !== 32'h0000_0010) begin errors++; $display("FAIL rd_dn_addr: got %h want 00000010", dn_addr); end
    checks++; if (up_wait !== 1'b1) begin errors++; $display("FAIL rd_wait_t1: got %b want 1", up_wait); end
    tick(); @(negedge clk);
    checks++; if (dn_rd !== 2'b00) begin errors++; $display("FAIL rd_pulse_once: got %b want 00", dn_rd); end
    checks++; if (dn_cs !== 2'b10) begin errors++; $display("FAIL rd_cs_wait: got %b want 10", dn_cs); end
    checks++; if (up_wait !== 1'b1) begin errors++; $display("FAIL rd_wait_t2: got %b want 1", up_wait); end
    tick(); @(negedge clk);
    checks++; if (up_wait !== 1'b0) begin errors++; $display("FAIL rd_wait_t3: got %b want 0", up_wait); end
    checks++; if (up_data_rd !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h want 12345678", up_data_rd); end
    checks++; if (up_err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", up_err); end
    checks++; if (dn_cs !== 2'b00) begin errors++; $display("FAIL rd_cs_done: got %b want 00", dn_cs); end
    exp_rd = 32'h1234_5678;
  endtask

  task automatic test_write_wait();
    logic [DW-1:0] w;
    int wcnt;
    @(negedge clk);
    w = $urandom;
    dn_data_rd = {32'($urandom), 32'($urandom)};
    dn_wait = 2'b01;
    up_wr = 1'b1; up_addr = mk_addr(4'd0, $urandom); up_data_wr = w;
    tick(); up_wr = 1'b0;
    wcnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (up_wait) begin
        wcnt++;
        checks++; if (dn_cs !== 2'b01) begin errors++; $display("FAIL wr_cs_held: cyc %0d got %b want 01", k, dn_cs); end
      end
      checks++; if (dn_rd !== 2'b00) begin errors++; $display("FAIL wr_no_rd: cyc %0d got %b want 00", k, dn_rd); end
      if (k == 1) begin
        checks++; if (dn_wr !== 2'b01) begin errors++; $display("FAIL wr_pulse: got %b want 01", dn_wr); end
        checks++; if (dn_data_wr !== w) begin errors++; $display("FAIL wr_data_out: got %h want %h", dn_data_wr, w); end
      end else begin
        checks++; if (dn_wr !== 2'b00) begin errors++; $display("FAIL wr_pulse_once: cyc %0d got %b want 00", k, dn_wr); end
      end
      tick();
      if (k == 3) begin up_rd = 1'b1; up_addr = mk_addr(4'd1, '0); end
      if (k == 4) up_rd = 1'b0;
      if (k == 6) dn_wait = 2'b00;
    end
    checks++; if (wcnt !== 7) begin errors++; $display("FAIL wr_wait_len: got %0d want 7", wcnt); end
    checks++; if (up_data_rd !== exp_rd) begin errors++; $display("FAIL wr_rd_held: got %h want %h", up_data_rd, exp_rd); end
    checks++; if (up_err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", up_err); end
  endtask

  task automatic test_bad_port_b2b();
    logic [DW-1:0] d0;
    @(negedge clk);
    dn_wait = '0;
    up_rd = 1'b1; up_addr = mk_addr(4'd5, $urandom);
    tick(); up_rd = 1'b0;
    @(negedge clk);
    checks++; if (up_wait !== 1'b1) begin errors++; $display("FAIL bad_wait_t1: got %b want 1", up_wait); end
    checks++; if ({dn_cs, dn_wr, dn_rd} !== 6'b0) begin errors++; $display("FAIL bad_no_dn: got %b/%b/%b want 0", dn_cs, dn_wr, dn_rd); end
    tick(); @(negedge clk);
    checks++; if (up_wait !== 1'b0) begin errors++; $display("FAIL bad_wait_t2: got %b want 0", up_wait); end
    checks++; if (up_err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b want 1", up_err); end
    checks++; if (up_data_rd !== ERRV) begin errors++; $display("FAIL bad_data: got %h want deadbeef", up_data_rd); end
    // strobe presented in DONE
    d0 = $urandom;
    dn_data_rd[0 +: DW] = d0;
    up_rd = 1'b1; up_addr = mk_addr(4'd0, $urandom);
    tick(); up_rd = 1'b0;
    @(negedge clk);
    checks++; if (dn_rd !== 2'b01) begin errors++; $display("FAIL b2b_pulse: got %b want 01", dn_rd); end
    checks++; if (up_err !== 1'b0) begin errors++; $display("FAIL b2b_err_clr: got %b want 0", up_err); end
    checks++; if (up_data_rd !== ERRV) begin errors++; $display("FAIL b2b_data_hold: got %h want deadbeef", up_data_rd); end
    tick(); tick(); @(negedge clk);
    checks++; if (up_wait !== 1'b0) begin errors++; $display("FAIL b2b_wait: got %b want 0", up_wait); end
    checks++; if (up_data_rd !== d0) begin errors++; $display("FAIL b2b_data: got %h want %h", up_data_rd, d0); end
    exp_rd = d0;
  endtask

  task automatic test_timeout();
    logic [DW-1:0] d;
    int wcnt;
    @(negedge clk);
    d = $urandom;
    dn_data_rd = {32'($urandom), d};
    dn_wait = 2'b01;
    up_rd = 1'b1; up_addr = mk_addr(4'd0, $urandom);
    tick(); up_rd = 1'b0;
    wcnt = 0;
`ifdef UP_TIMEOUT_EN
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!up_wait) break;
      wcnt++;
      tick();
    end
    checks++; if (wcnt !== 1 + TO) begin errors++; $display("FAIL to_wait_len: got %0d want %0d", wcnt, 1 + TO); end
    checks++; if (up_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", up_err); end
    checks++; if (up_data_rd !== ERRV) begin errors++; $display("FAIL to_data: got %h want deadbeef", up_data_rd); end
    checks++; if (dn_cs !== 2'b00) begin errors++; $display("FAIL to_cs_drop: got %b want 00", dn_cs); end
    exp_rd = ERRV;
    dn_wait = '0;
`else
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (up_wait) wcnt++;
      tick();
    end
    checks++; if (wcnt !== 40) begin errors++; $display("FAIL nto_wait_len: got %0d want 40", wcnt); end
    dn_wait = '0;
    @(negedge clk);
    checks++; if (up_wait !== 1'b1) begin errors++; $display("FAIL nto_wait_rel: got %b want 1", up_wait); end
    tick(); @(negedge clk);
    checks++; if (up_wait !== 1'b0) begin errors++; $display("FAIL nto_done: got %b want 0", up_wait); end
    checks++; if (up_err !== 1'b0) begin errors++; $display("FAIL nto_err: got %b want 0", up_err); end
    checks++; if (up_data_rd !== d) begin errors++; $display("FAIL nto_data: got %h want %h", up_data_rd, d); end
    exp_rd = d;
`endif
    // next strobe behaves normally
    @(negedge clk);
    d = $urandom;
    dn_data_rd[DW +: DW] = d;
    up_rd = 1'b1; up_addr = mk_addr(4'd1, $urandom);
    tick(); up_rd = 1'b0;
    tick(); tick(); @(negedge clk);
    checks++; if (up_wait !== 1'b0) begin errors++; $display("FAIL to_next_wait: got %b want 0", up_wait); end
    checks++; if (up_err !== 1'b0) begin errors++; $display("FAIL to_next_err: got %b want 0", up_err); end
    checks++; if (up_data_rd !== d) begin errors++; $display("FAIL to_next_data: got %h want %h", up_data_rd, d); end
    exp_rd = d;
  endtask

  task automatic test_reset_abort();
    logic [DW-1:0] d;
    @(negedge clk);
    dn_wait = 2'b10;
    up_rd = 1'b1; up_addr = mk_addr(4'd1, $urandom); up_data_wr = $urandom;
    tick(); up_rd = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; dn_wait = '0;
    @(negedge clk);
    checks++; if ({up_wait, up_err} !== 2'b00) begin errors++; $display("FAIL abort_flags: got %b%b want 00", up_wait, up_err); end
    checks++; if (up_data_rd !== 32'h0) begin errors++; $display("FAIL abort_data: got %h want 0", up_data_rd); end
    checks++; if ({dn_cs, dn_wr, dn_rd} !== 6'b0) begin errors++; $display("FAIL abort_dn: got %b/%b/%b want 0", dn_cs, dn_wr, dn_rd); end
    checks++; if ({dn_addr, dn_data_wr} !== 64'h0) begin errors++; $display("FAIL abort_latches: got %h/%h want 0", dn_addr, dn_data_wr); end
    exp_rd = '0;
    tick(); @(negedge clk);
    checks++; if ({dn_rd, up_wait} !== 3'b000) begin errors++; $display("FAIL abort_no_repeat: got %b/%b want 0", dn_rd, up_wait); end
    d = $urandom;
    dn_data_rd[0 +: DW] = d;
    up_rd = 1'b1; up_addr = mk_addr(4'd0, $urandom);
    tick(); up_rd = 1'b0;
    @(negedge clk);
    checks++; if ({dn_rd, up_wait} !== 3'b011) begin errors++; $display("FAIL after_rst_t1: got %b/%b want 01/1", dn_rd, up_wait); end
    tick(); @(negedge clk);
    checks++; if (up_wait !== 1'b1) begin errors++; $display("FAIL after_rst_t2: got %b want 1", up_wait); end
    tick(); @(negedge clk);
    checks++; if (up_wait !== 1'b0) begin errors++; $display("FAIL after_rst_t3: got %b want 0", up_wait); end
    checks++; if (up_data_rd !== d) begin errors++; $display("FAIL after_rst_data: got %h want %h", up_data_rd, d); end
    exp_rd = d;
  endtask

  task automatic test_random_txn();
    logic [3:0]    sel;
    logic          wr, valid;
    int            extra, gap, cyc, wcnt, exp_wcnt;
    logic [AW-1:0] a;
    logic [DW-1:0] wdata, pd0, pd1;
    logic [NP-1:0] hot;
    @(negedge clk);
    for (int n = 0; n < 40; n++) begin
      sel   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
      wr    = 1'($urandom_range(0, 1));
      extra = $urandom_range(0, 4);
      gap   = $urandom_range(0, 2);
      valid = (int'(sel) < NP);
      hot   = valid ? (2'b01 << sel) : 2'b00;
      for (int g = 0; g < gap; g++) @(negedge clk);
      a = mk_addr(sel, $urandom);
      wdata = $urandom; pd0 = $urandom; pd1 = $urandom;
      dn_data_rd = {pd1, pd0};
      dn_wait = ((extra > 0) ? hot : 2'b00) | (~hot & 2'($urandom));
      up_wr = wr; up_rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      up_addr = a; up_data_wr = wdata;
      tick(); up_wr = 1'b0; up_rd = 1'b0;
      @(negedge clk);
      checks++; if (dn_cs !== hot) begin errors++; $display("FAIL rnd_cs: txn %0d got %b want %b", n, dn_cs, hot); end
      checks++; if (dn_wr !== (wr ? hot : 2'b00)) begin errors++; $display("FAIL rnd_wr: txn %0d got %b", n, dn_wr); end
      checks++; if (dn_rd !== (wr ? 2'b00 : hot)) begin errors++; $display("FAIL rnd_rd: txn %0d got %b", n, dn_rd); end
      checks++; if (dn_addr !== (a & ADDR_KEEP)) begin errors++; $display("FAIL rnd_addr: txn %0d got %h want %h", n, dn_addr, a & ADDR_KEEP); end
      checks++; if (dn_data_wr !== wdata) begin errors++; $display("FAIL rnd_wdata: txn %0d got %h want %h", n, dn_data_wr, wdata); end
      cyc = 1; wcnt = 0;
      for (int k = 0; k < 30; k++) begin
        if (!up_wait) break;
        wcnt++;
        tick(); cyc++;
        if (cyc == 2 + extra) dn_wait = dn_wait & ~hot;
        @(negedge clk);
      end
      exp_wcnt = valid ? 2 + extra : 1;
      if (!valid) exp_rd = ERRV;
      else if (!wr) exp_rd = (sel == 4'd0) ? pd0 : pd1;
      checks++; if (wcnt !== exp_wcnt) begin errors++; $display("FAIL rnd_wait_len: txn %0d got %0d want %0d", n, wcnt, exp_wcnt); end
      checks++; if (up_err !== !valid) begin errors++; $display("FAIL rnd_err: txn %0d got %b want %b", n, up_err, !valid); end
      checks++; if (up_data_rd !== exp_rd) begin errors++; $display("FAIL rnd_data: txn %0d got %h want %h", n, up_data_rd, exp_rd); end
      checks++; if (dn_cs !== 2'b00) begin errors++; $display("FAIL rnd_cs_done: txn %0d got %b want 00", n, dn_cs); end
    end
    dn_wait = '0;
  endtask

  task automatic test_led_window();
    logic [NP-1:0] exp_tx;
    @(negedge clk);
    rst = 1'b1; act_tx = '0; act_rx = '0;
    tick(); rst = 1'b0;
    for (int c = 0; c < 64; c++) begin
      act_tx = (c == 20) ? 2'b10 : 2'b00;
      @(negedge clk);
      exp_tx = (c / 16 == 2) ? 2'b01 : 2'b11;
      checks++; if (led_tx !== exp_tx) begin errors++; $display("FAIL led_win_tx: cyc %0d got %b want %b", c, led_tx, exp_tx); end
      checks++; if (led_rx !== 2'b11) begin errors++; $display("FAIL led_win_rx: cyc %0d got %b want 11", c, led_rx); end
      tick();
    end
    act_tx = '0;
  endtask

  task automatic test_led_random();
    logic [NP-1:0] ltx [128];
    logic [NP-1:0] lrx [128];
    logic [NP-1:0] etx, erx;
    int w;
    @(negedge clk);
    rst = 1'b1; act_tx = '0; act_rx = '0;
    tick(); rst = 1'b0;
    for (int c = 0; c < 128; c++) begin
      for (int p = 0; p < NP; p++) begin
        ltx[c][p] = ($urandom_range(0, 19) == 0);
        lrx[c][p] = ($urandom_range(0, 19) == 0);
      end
      if (c == 47) lrx[c][0] = 1'b1;
      act_tx = ltx[c]; act_rx = lrx[c];
      @(negedge clk);
      // activity in cycle a lands in window (a+1)/16 and lights the LED through the window after
      w = c / 16;
      etx = 2'b11; erx = 2'b11;
      for (int a = 0; a <= c; a++) begin
        if (w >= 1 && (a + 1) / 16 == w - 1) begin
          etx = etx & ~ltx[a];
          erx = erx & ~lrx[a];
        end
      end
      checks++; if (led_tx !== etx) begin errors++; $display("FAIL led_rnd_tx: cyc %0d got %b want %b", c, led_tx, etx); end
      checks++; if (led_rx !== erx) begin errors++; $display("FAIL led_rnd_rx: cyc %0d got %b want %b", c, led_rx, erx); end
      tick();
    end
    act_tx = '0; act_rx = '0;
  endtask

  initial begin
    test_reset();
    test_read_min();
    test_write_wait();
    test_bad_port_b2b();
    test_timeout();
    test_reset_abort();
    test_random_txn();
    test_led_window();
    test_led_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
